// File: rtl/exu_lsu_ctrl.sv
// rtl/exu_lsu_ctrl.sv - load/store control between AGU, BIU and commit write-back
// In-order tag FIFO tracks outstanding bus transactions; one registered write-back entry.
module exu_lsu_ctrl #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int ITAG_WIDTH = 2,
  parameter int OUTS_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_req,
  input  logic                          agu_cmd_valid,
  output logic                          agu_cmd_ready,
  input  logic [ADDR_SIZE-1:0]          agu_cmd_addr,
  input  logic                          agu_cmd_read,
  input  logic [XLEN-1:0]               agu_cmd_wdata,
  input  logic [ITAG_WIDTH-1:0]         agu_cmd_itag,
  input  logic [1:0]                    agu_cmd_size,
  input  logic                          agu_cmd_usign,
  output logic                          biu_cmd_valid,
  input  logic                          biu_cmd_ready,
  output logic [ADDR_SIZE-1:0]          biu_cmd_addr,
  output logic                          biu_cmd_read,
  output logic [XLEN-1:0]               biu_cmd_wdata,
  output logic [3:0]                    biu_cmd_wmask,
  input  logic                          biu_rsp_valid,
  output logic                          biu_rsp_ready,
  input  logic [XLEN-1:0]               biu_rsp_rdata,
  input  logic                          biu_rsp_err,
  output logic                          lsu_o_valid,
  input  logic                          lsu_o_ready,
  output logic [XLEN-1:0]               lsu_o_wbck_wdat,
  output logic [ITAG_WIDTH-1:0]         lsu_o_wbck_itag,
  output logic                          lsu_o_wbck_err,
  output logic                          lsu_o_wbck_load,
  output logic [$clog2(OUTS_DEPTH):0]   lsu_outs_cnt
);

  localparam int PW = $clog2(OUTS_DEPTH);
  localparam int EW = ITAG_WIDTH + 6;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTS_DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);

  logic [EW-1:0]         fifo_mem [OUTS_DEPTH];
  logic [PW:0]           wr_ptr, rd_ptr, cnt;
  logic                  fifo_full, push, pop;

  logic [ITAG_WIDTH-1:0] head_itag;
  logic                  head_read, head_usign;
  logic [1:0]            head_size, head_ofs;

  logic [XLEN-1:0]       sh, ld_data, wb_data_nxt;
  logic                  wb_vld;
  logic [XLEN-1:0]       wb_wdat;
  logic [ITAG_WIDTH-1:0] wb_itag;
  logic                  wb_err, wb_load;

  // Full blocks acceptance even if a pop lands in the same cycle (no bypass).
  assign fifo_full     = (cnt == FULL_CNT);
  assign biu_cmd_valid = agu_cmd_valid & ~fifo_full & ~flush_req;
  assign agu_cmd_ready = biu_cmd_ready & ~fifo_full & ~flush_req;
  assign push          = agu_cmd_valid & agu_cmd_ready;

  assign biu_cmd_addr  = {agu_cmd_addr[ADDR_SIZE-1:2], 2'b00};
  assign biu_cmd_read  = agu_cmd_read;
  assign biu_cmd_wdata = agu_cmd_wdata;

  always_comb begin
    biu_cmd_wmask = 4'b0000;
    if (!agu_cmd_read) begin
      case (agu_cmd_size)
        2'b00:   biu_cmd_wmask = 4'b0001 << agu_cmd_addr[1:0];
        2'b01:   biu_cmd_wmask = 4'b0011 << {agu_cmd_addr[1], 1'b0};
        default: biu_cmd_wmask = 4'b1111;
      endcase
    end
  end

  assign biu_rsp_ready = (cnt != '0) & (~wb_vld | lsu_o_ready);
  assign pop           = biu_rsp_valid & biu_rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= {agu_cmd_itag, agu_cmd_read, agu_cmd_size,
                                   agu_cmd_usign, agu_cmd_addr[1:0]};
    end
  end

  assign {head_itag, head_read, head_size, head_usign, head_ofs} = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    sh = biu_rsp_rdata >> {head_ofs, 3'b000};
    case (head_size)
      2'b00:   ld_data = {{(XLEN-8){sh[7] & ~head_usign}}, sh[7:0]};
      2'b01:   ld_data = {{(XLEN-16){sh[15] & ~head_usign}}, sh[15:0]};
      default: ld_data = sh;
    endcase
    wb_data_nxt = (head_read & ~biu_rsp_err) ? ld_data : '0;
  end

  // A pop while the buffer drains replaces the contents and keeps wb_vld high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wb_vld  <= 1'b0;
      wb_wdat <= '0;
      wb_itag <= '0;
      wb_err  <= 1'b0;
      wb_load <= 1'b0;
    end else if (pop) begin
      wb_vld  <= 1'b1;
      wb_wdat <= wb_data_nxt;
      wb_itag <= head_itag;
      wb_err  <= biu_rsp_err;
      wb_load <= head_read;
    end else if (lsu_o_ready) begin
      wb_vld  <= 1'b0;
    end
  end

  assign lsu_o_valid     = wb_vld;
  assign lsu_o_wbck_wdat = wb_wdat;
  assign lsu_o_wbck_itag = wb_itag;
  assign lsu_o_wbck_err  = wb_err;
  assign lsu_o_wbck_load = wb_load;
  assign lsu_outs_cnt    = cnt;

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// tb/tb_exu_lsu_ctrl.sv - scoreboard bench for exu_lsu_ctrl
module tb_exu_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_req;
  logic        agu_cmd_valid, agu_cmd_ready;
  logic [31:0] agu_cmd_addr;
  logic        agu_cmd_read;
  logic [31:0] agu_cmd_wdata;
  logic [1:0]  agu_cmd_itag;
  logic [1:0]  agu_cmd_size;
  logic        agu_cmd_usign;
  logic        biu_cmd_valid, biu_cmd_ready;
  logic [31:0] biu_cmd_addr;
  logic        biu_cmd_read;
  logic [31:0] biu_cmd_wdata;
  logic [3:0]  biu_cmd_wmask;
  logic        biu_rsp_valid, biu_rsp_ready;
  logic [31:0] biu_rsp_rdata;
  logic        biu_rsp_err;
  logic        lsu_o_valid, lsu_o_ready;
  logic [31:0] lsu_o_wbck_wdat;
  logic [1:0]  lsu_o_wbck_itag;
  logic        lsu_o_wbck_err, lsu_o_wbck_load;
  logic [1:0]  lsu_outs_cnt;

  exu_lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_itag(agu_cmd_itag),
    .agu_cmd_size(agu_cmd_size), .agu_cmd_usign(agu_cmd_usign),
    .biu_cmd_valid(biu_cmd_valid), .biu_cmd_ready(biu_cmd_ready),
    .biu_cmd_addr(biu_cmd_addr), .biu_cmd_read(biu_cmd_read),
    .biu_cmd_wdata(biu_cmd_wdata), .biu_cmd_wmask(biu_cmd_wmask),
    .biu_rsp_valid(biu_rsp_valid), .biu_rsp_ready(biu_rsp_ready),
    .biu_rsp_rdata(biu_rsp_rdata), .biu_rsp_err(biu_rsp_err),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
    .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_wbck_itag(lsu_o_wbck_itag),
    .lsu_o_wbck_err(lsu_o_wbck_err), .lsu_o_wbck_load(lsu_o_wbck_load),
    .lsu_outs_cnt(lsu_outs_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        read;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic [31:0] wdat;
    logic [1:0]  itag;
    logic        err;
    logic        load;
  } wb_t;

  cmd_t cmd_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_cmd
    cmd_t e;
    if (!rst_n && biu_cmd_valid && biu_cmd_ready) begin
      if (cmd_q.size() == 0) begin
        check("cmd_unexpected", biu_cmd_addr, 32'hFFFF_FFFF);
      end else begin
        e = cmd_q.pop_front();
        check("cmd_addr", biu_cmd_addr, e.addr);
        check("cmd_read", {31'd0, biu_cmd_read}, {31'd0, e.read});
        check("cmd_wmask", {28'd0, biu_cmd_wmask}, {28'd0, e.wmask});
        check("cmd_wdata", biu_cmd_wdata, e.wdata);
      end
    end
  end

  always @(negedge clk) begin : mon_wb
    wb_t e;
    if (!rst_n && lsu_o_valid && lsu_o_ready) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", lsu_o_wbck_wdat, 32'hFFFF_FFFF);
      end else begin
        e = wb_q.pop_front();
        check("wb_wdat", lsu_o_wbck_wdat, e.wdat);
        check("wb_itag", {30'd0, lsu_o_wbck_itag}, {30'd0, e.itag});
        check("wb_err", {31'd0, lsu_o_wbck_err}, {31'd0, e.err});
        check("wb_load", {31'd0, lsu_o_wbck_load}, {31'd0, e.load});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                          input logic [1:0] itag, input logic [1:0] size, input logic usign,
                          input logic [31:0] exp_addr, input logic [3:0] exp_mask);
    cmd_t c;
    agu_cmd_valid = 1'b1;
    agu_cmd_addr  = addr;
    agu_cmd_read  = rd;
    agu_cmd_wdata = wdata;
    agu_cmd_itag  = itag;
    agu_cmd_size  = size;
    agu_cmd_usign = usign;
    c.addr = exp_addr; c.read = rd; c.wmask = exp_mask; c.wdata = wdata;
    cmd_q.push_back(c);
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                          input logic [1:0] itag, input logic [1:0] size, input logic usign,
                          input logic [31:0] exp_addr, input logic [3:0] exp_mask);
    bit ok = 0;
    push_cmd(addr, rd, wdata, itag, size, usign, exp_addr, exp_mask);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (agu_cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
    tick();
    agu_cmd_valid = 1'b0;
  endtask

  task automatic expect_wb(input logic [31:0] wdat, input logic [1:0] itag,
                           input logic err, input logic load);
    wb_t w;
    w.wdat = wdat; w.itag = itag; w.err = err; w.load = load;
    wb_q.push_back(w);
  endtask

  task automatic send_rsp(input logic [31:0] rdata, input logic err);
    bit ok = 0;
    biu_rsp_valid = 1'b1;
    biu_rsp_rdata = rdata;
    biu_rsp_err   = err;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (biu_rsp_ready) begin ok = 1; break; end
    end
    if (!ok) check("rsp_accept_timeout", 32'd0, 32'd1);
    tick();
    biu_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; flush_req = 1'b0;
    agu_cmd_valid = 1'b0; agu_cmd_addr = '0; agu_cmd_read = 1'b0; agu_cmd_wdata = '0;
    agu_cmd_itag = '0; agu_cmd_size = '0; agu_cmd_usign = 1'b0;
    biu_cmd_ready = 1'b1; biu_rsp_valid = 1'b0; biu_rsp_rdata = '0; biu_rsp_err = 1'b0;
    lsu_o_ready = 1'b1;
    repeat (2) tick();
    check("rst_lsu_valid", {31'd0, lsu_o_valid}, 32'd0);
    check("rst_cnt", {30'd0, lsu_outs_cnt}, 32'd0);
    check("rst_rsp_ready", {31'd0, biu_rsp_ready}, 32'd0);
    check("rst_agu_ready", {31'd0, agu_cmd_ready}, 32'd1);
    rst_n = 1'b0;
    tick();

    // signed / unsigned byte loads
    send_cmd(32'h1003, 1'b1, 32'h0, 2'd1, 2'b00, 1'b0, 32'h1000, 4'b0000);
    check("lb_cnt", {30'd0, lsu_outs_cnt}, 32'd1);
    expect_wb(32'hFFFF_FF80, 2'd1, 1'b0, 1'b1);
    send_rsp(32'h8000_0000, 1'b0);
    check("lb_latency_valid", {31'd0, lsu_o_valid}, 32'd1);
    send_cmd(32'h1003, 1'b1, 32'h0, 2'd0, 2'b00, 1'b1, 32'h1000, 4'b0000);
    expect_wb(32'h0000_0080, 2'd0, 1'b0, 1'b1);
    send_rsp(32'h8000_0000, 1'b0);

    // halfword store
    send_cmd(32'h0102, 1'b0, 32'hABCD_ABCD, 2'd2, 2'b01, 1'b0, 32'h0100, 4'b1100);
    expect_wb(32'h0, 2'd2, 1'b0, 1'b0);
    send_rsp(32'hDEAD_BEEF, 1'b0);
    send_cmd(32'h0201, 1'b0, 32'h5A5A_5A5A, 2'd3, 2'b00, 1'b0, 32'h0200, 4'b0010);
    expect_wb(32'h0, 2'd3, 1'b0, 1'b0);
    send_rsp(32'h0, 1'b0);
    tick();

    // FIFO full with three back-to-back loads
    push_cmd(32'h2000, 1'b1, 32'h0, 2'd0, 2'b10, 1'b0, 32'h2000, 4'b0000);
    tick();
    check("full_cnt1", {30'd0, lsu_outs_cnt}, 32'd1);
    push_cmd(32'h2004, 1'b1, 32'h0, 2'd1, 2'b10, 1'b0, 32'h2004, 4'b0000);
    tick();
    push_cmd(32'h2008, 1'b1, 32'h0, 2'd3, 2'b10, 1'b0, 32'h2008, 4'b0000);
    check("full_cnt2", {30'd0, lsu_outs_cnt}, 32'd2);
    check("full_agu_ready", {31'd0, agu_cmd_ready}, 32'd0);
    check("full_biu_valid", {31'd0, biu_cmd_valid}, 32'd0);
    expect_wb(32'h1111_1111, 2'd0, 1'b0, 1'b1);
    biu_rsp_valid = 1'b1; biu_rsp_rdata = 32'h1111_1111; biu_rsp_err = 1'b0;
    tick();
    biu_rsp_valid = 1'b0;
    check("pop_cnt", {30'd0, lsu_outs_cnt}, 32'd1);
    check("pop_agu_ready", {31'd0, agu_cmd_ready}, 32'd1);
    tick();
    agu_cmd_valid = 1'b0;
    check("refill_cnt", {30'd0, lsu_outs_cnt}, 32'd2);

    // write-back backpressure on the two outstanding loads
    lsu_o_ready = 1'b0;
    expect_wb(32'h2222_2222, 2'd1, 1'b0, 1'b1);
    biu_rsp_valid = 1'b1; biu_rsp_rdata = 32'h2222_2222;
    tick();
    expect_wb(32'h3333_3333, 2'd3, 1'b0, 1'b1);
    biu_rsp_rdata = 32'h3333_3333;
    check("bp_valid", {31'd0, lsu_o_valid}, 32'd1);
    check("bp_rsp_ready", {31'd0, biu_rsp_ready}, 32'd0);
    check("bp_wdat0", lsu_o_wbck_wdat, 32'h2222_2222);
    tick();
    check("bp_wdat1", lsu_o_wbck_wdat, 32'h2222_2222);
    check("bp_cnt", {30'd0, lsu_outs_cnt}, 32'd1);
    lsu_o_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, biu_rsp_ready}, 32'd1);
    tick();
    biu_rsp_valid = 1'b0;
    check("bp_refill_valid", {31'd0, lsu_o_valid}, 32'd1);
    check("bp_refill_cnt", {30'd0, lsu_outs_cnt}, 32'd0);
    tick();

    // flush blocks acceptance; outstanding load completes with bus error
    send_cmd(32'h3000, 1'b1, 32'h0, 2'd2, 2'b10, 1'b0, 32'h3000, 4'b0000);
    flush_req = 1'b1;
    agu_cmd_valid = 1'b1; agu_cmd_addr = 32'h3004;
    #1;
    check("flush_biu_valid", {31'd0, biu_cmd_valid}, 32'd0);
    check("flush_agu_ready", {31'd0, agu_cmd_ready}, 32'd0);
    expect_wb(32'h0, 2'd2, 1'b1, 1'b1);
    send_rsp(32'h0000_1234, 1'b1);
    check("flush_cnt", {30'd0, lsu_outs_cnt}, 32'd0);
    agu_cmd_valid = 1'b0; flush_req = 1'b0; biu_rsp_err = 1'b0;
    tick();

    // asynchronous reset mid-operation
    send_cmd(32'h4000, 1'b1, 32'h0, 2'd0, 2'b10, 1'b0, 32'h4000, 4'b0000);
    send_cmd(32'h4004, 1'b1, 32'h0, 2'd1, 2'b10, 1'b0, 32'h4004, 4'b0000);
    lsu_o_ready = 1'b0;
    biu_rsp_valid = 1'b1; biu_rsp_rdata = 32'h4444_4444;
    tick();
    biu_rsp_valid = 1'b0;
    check("pre_rst_valid", {31'd0, lsu_o_valid}, 32'd1);
    check("pre_rst_cnt", {30'd0, lsu_outs_cnt}, 32'd1);
    #2 rst_n = 1'b1;
    #1;
    check("arst_valid", {31'd0, lsu_o_valid}, 32'd0);
    check("arst_cnt", {30'd0, lsu_outs_cnt}, 32'd0);
    check("arst_rsp_ready", {31'd0, biu_rsp_ready}, 32'd0);
    check("arst_wdat", lsu_o_wbck_wdat, 32'd0);
    lsu_o_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    send_cmd(32'h5008, 1'b1, 32'h0, 2'd3, 2'b10, 1'b0, 32'h5008, 4'b0000);
    expect_wb(32'hCAFE_F00D, 2'd3, 1'b0, 1'b1);
    send_rsp(32'hCAFE_F00D, 1'b0);
    repeat (3) tick();

    check("cmd_q_empty", cmd_q.size(), 32'd0);
    check("wb_q_empty", wb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_lsu_ctrl.md
Name: exu_lsu_ctrl

Overview:
Load/store control unit between the AGU command/response channels and the bus interface unit (BIU). Forwards aligned AGU commands to the BIU with byte-lane write masks and tracks outstanding transactions in an in-order tag FIFO. Aligns and sign/zero-extends load data and returns one write-back per transaction (load data or store ack, with error flag) to the commit stage.

Parameters:
XLEN, 32, data width; only 32 is supported.
ADDR_SIZE, 32, address width.
ITAG_WIDTH, 2, instruction tag width.
OUTS_DEPTH, 2, maximum outstanding BIU transactions; must be a power of 2 and at least 2.

Ports:
clk  in  1  single clock.
rst_n  in  1  reset; one clock; reset is asynchronous and active-high.
flush_req  in  1  pipeline flush request; blocks new command acceptance.
agu_cmd_valid  in  1  AGU command valid.
agu_cmd_ready  out  1  AGU command ready.
agu_cmd_addr  in  ADDR_SIZE  byte address.
agu_cmd_read  in  1  1 = load, 0 = store.
agu_cmd_wdata  in  XLEN  lane-replicated store data.
agu_cmd_itag  in  ITAG_WIDTH  instruction tag.
agu_cmd_size  in  2  00 = byte, 01 = halfword, 1x = word.
agu_cmd_usign  in  1  zero-extend load.
biu_cmd_valid  out  1  bus command valid.
biu_cmd_ready  in  1  bus command ready.
biu_cmd_addr  out  ADDR_SIZE  agu_cmd_addr with bits [1:0] forced to 0.
biu_cmd_read  out  1  read/write.
biu_cmd_wdata  out  XLEN  pass-through of agu_cmd_wdata.
biu_cmd_wmask  out  4  byte enables; 0000 for reads.
biu_rsp_valid  in  1  bus response valid.
biu_rsp_ready  out  1  bus response ready.
biu_rsp_rdata  in  XLEN  response data.
biu_rsp_err  in  1  bus error.
lsu_o_valid  out  1  write-back valid.
lsu_o_ready  in  1  write-back ready.
lsu_o_wbck_wdat  out  XLEN  extended load data; 0 for stores or errors.
lsu_o_wbck_itag  out  ITAG_WIDTH  tag of the completing transaction.
lsu_o_wbck_err  out  1  bus error for the transaction.
lsu_o_wbck_load  out  1  1 = load, 0 = store ack.
lsu_outs_cnt  out  $clog2(OUTS_DEPTH)+1  outstanding transaction count.

Behaviour:
- Command path is combinational: fifo_full = (cnt == OUTS_DEPTH).
  - biu_cmd_valid = agu_cmd_valid & ~fifo_full & ~flush_req.
  - agu_cmd_ready = biu_cmd_ready & ~fifo_full & ~flush_req.
- Write mask:
  - byte: 0001 << addr[1:0].
  - halfword: 0011 << {addr[1],1'b0}.
  - word: 1111.
  - Alignment is guaranteed upstream and not checked here.
- On command handshake, push {itag, read, size, usign, addr[1:0]} into the tag FIFO.
- Tag FIFO: OUTS_DEPTH entries; rd/wr pointers with an extra wrap bit; cnt increments on push and decrements on pop.
  - Full blocks a push even when a pop happens in the same cycle, so ready rises the cycle after the pop.
  - Simultaneous push and pop when not full leaves cnt unchanged.
- Write-back buffer: one entry registered.
  - biu_rsp_ready = (cnt != 0) & (~wb_vld | lsu_o_ready).
  - Response handshake pops the FIFO head and loads the buffer. The buffer is valid the next cycle, so latency is 1 cycle from rsp handshake to lsu_o_valid.
  - If the buffer drains and refills in the same cycle, wb_vld stays 1 and the contents are replaced.
- Load data: sh = rdata >> (addr[1:0]*8).
  - byte: bits [7:0], extended with bit 7 unless usign.
  - halfword: bits [15:0], extended with bit 15 unless usign.
  - word: unchanged.
- Store, or biu_rsp_err = 1: wdat = 0. err is copied through; itag comes from the FIFO head.
- Response with cnt == 0 cannot occur, because ready is held low.
- flush_req affects only new acceptance. Outstanding transactions complete and write back normally; commit discards them by itag.
- Reset (asynchronous, any time, including mid-transaction):
  - Pointers and cnt go to 0; wb_vld goes to 0; buffer data, itag, err and load go to 0.
  - Combinational outputs follow from the reset state: agu_cmd_ready = biu_cmd_ready & ~flush_req, biu_rsp_ready = 0.
  - In-flight bus responses after reset are the BIU's responsibility; the BIU is reset by the same signal.
- Pipelining: accepts one command per cycle and retires one response per cycle in steady state.

Test Plan:
- Signed and unsigned byte load:
  - lb addr 0x1003, rsp rdata 0x80000000 → biu_cmd_addr 0x1000, wmask 0000; one cycle later lsu_o_valid=1, wdat 0xFFFFFF80, load=1.
  - Repeat with usign=1 → wdat 0x00000080.
- Halfword store: sh addr 0x0102, wdata 0xABCDABCD, itag 2 → wmask 1100, wdata unchanged; rsp err=0 → wdat 0, itag 2, load=0.
- FIFO full: 3 back-to-back commands, BIU ready=1, no responses → cmds 1 and 2 accepted, cnt=2, agu_cmd_ready=0 on cmd 3. Next, one response → cmd 3 accepted the cycle after the pop, cnt back to 2.
- Write-back backpressure: lsu_o_ready=0 with 2 outstanding → first response buffered with output stable; biu_rsp_ready=0 for the second. When lsu_o_ready=1 → the second response is accepted that same cycle, and the two write-backs come out in order.
- Flush and error: flush_req=1 with agu_cmd_valid=1 → biu_cmd_valid=0, cnt unchanged. Outstanding lw with rsp err=1, rdata 0x1234 → wdat 0, err=1.
- Reset mid-operation: 2 outstanding and wb_vld=1, assert reset → lsu_o_valid=0, cnt=0, biu_rsp_ready=0 immediately. After release, a new lw works normally.
